rv_iommu_atr_requester: RTL and testbench

- Device-side initiator of the IOMMU address-translation request/completion protocol; the requesting end of the atr_*/atc_* buses.
- Accepts translation requests from a client (device ATC or DMA engine), allocates a tag, drives the atr_* bus, and tracks each outstanding tag.
- Matches atc_* completions by tag and returns them to the client with the original IOVA echoed.
- Generates a local timeout completion for lost responses; serves as bench driver and as device-side integration logic.

---
 rtl/rv_iommu_atr_requester_pkg.sv | 42 ++++
 rtl/rv_iommu_atr_tag_table.sv | 97 +++++++++
 rtl/rv_iommu_atr_requester.sv | 207 ++++++++++++++++++++
 tb/tb_rv_iommu_atr_requester.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iommu_atr_requester_pkg.sv
// Shared definitions for the device-side address-translation requester:
// ATS completion status codes, response flag layout, request bundle and slot states.
package rv_iommu_atr_requester_pkg;

  localparam logic [2:0] AtsSuccess = 3'b000;
  localparam logic [2:0] AtsUr      = 3'b001;
  localparam logic [2:0] AtsCrs     = 3'b010;
  localparam logic [2:0] AtsCa      = 3'b100;
  // Never produced by the IOMMU; generated locally when a completion is lost.
  localparam logic [2:0] AtsTimeout = 3'b111;

  localparam int unsigned FlagW       = 0;
  localparam int unsigned FlagR       = 1;
  localparam int unsigned FlagU       = 2;
  localparam int unsigned FlagExe     = 3;
  localparam int unsigned FlagPriv    = 4;
  localparam int unsigned FlagG       = 5;
  localparam int unsigned FlagCxlIo   = 6;
  localparam int unsigned FlagNoSnoop = 7;
  localparam int unsigned FlagSize    = 8;
  localparam int unsigned NumFlags    = 9;

  typedef struct packed {
    logic [51:0] iova;
    logic [23:0] device_id;
    logic [19:0] process_id;
    logic [1:0]  addr_type;
    logic        read_write;
    logic        pid_valid;
    logic        no_write;
    logic        exec_req;
    logic        priv_req;
    logic        tee_req;
  } atr_req_t;

  typedef enum logic [1:0] {
    SlotFree,
    SlotPend,
    SlotStale
  } slot_state_e;

endpackage

// File: rtl/rv_iommu_atr_tag_table.sv
// Per-tag slot tracking: state, stored IOVA and age counter, plus the
// lowest-free and lowest-timed-out priority encoders.
module rv_iommu_atr_tag_table
  import rv_iommu_atr_requester_pkg::*;
#(
  parameter int unsigned NUM_TAGS       = 8,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc_i,
  input  logic [51:0]                       alloc_iova_i,
  output logic                              any_free_o,
  output logic [$clog2(NUM_TAGS)-1:0]       free_idx_o,
  input  logic                              cpl_i,
  input  logic [7:0]                        cpl_tag_i,
  output logic                              cpl_pend_o,
  output logic                              cpl_stale_o,
  output logic [51:0]                       cpl_iova_o,
  input  logic                              to_take_i,
  output logic                              to_valid_o,
  output logic [51:0]                       to_iova_o,
  output logic [$clog2(NUM_TAGS+1)-1:0]     stale_cnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_TAGS);
  localparam int unsigned CntW = $clog2(NUM_TAGS + 1);
  localparam logic [TIMEOUT_W-1:0] AgeLimit = TIMEOUT_W'(TIMEOUT_CYCLES);

  slot_state_e          state_q [NUM_TAGS];
  logic [51:0]          iova_q  [NUM_TAGS];
  logic [TIMEOUT_W-1:0] age_q   [NUM_TAGS];

  logic            cpl_in_range;
  logic [IdxW-1:0] cpl_idx;
  logic [IdxW-1:0] to_idx;

  assign cpl_in_range = 32'(cpl_tag_i) < NUM_TAGS;
  assign cpl_idx      = cpl_tag_i[IdxW-1:0];
  assign cpl_pend_o   = cpl_in_range && (state_q[cpl_idx] == SlotPend);
  assign cpl_stale_o  = cpl_in_range && (state_q[cpl_idx] == SlotStale);
  assign cpl_iova_o   = iova_q[cpl_idx];
  assign to_iova_o    = iova_q[to_idx];

  // Descending scan so the lowest matching index wins.
  always_comb begin
    any_free_o  = 1'b0;
    free_idx_o  = '0;
    to_valid_o  = 1'b0;
    to_idx      = '0;
    stale_cnt_o = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (state_q[i] == SlotFree) begin
        any_free_o = 1'b1;
        free_idx_o = IdxW'(i);
      end
      if (state_q[i] == SlotPend && age_q[i] == AgeLimit) begin
        to_valid_o = 1'b1;
        to_idx     = IdxW'(i);
      end
      if (state_q[i] == SlotStale) begin
        stale_cnt_o = stale_cnt_o + CntW'(1);
      end
    end
  end

  // Allocation, completion and timeout always target distinct slots, so their
  // updates never collide within one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        state_q[i] <= SlotFree;
        iova_q[i]  <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (state_q[i] == SlotPend && age_q[i] != AgeLimit) begin
          age_q[i] <= age_q[i] + TIMEOUT_W'(1);
        end
        if (cpl_i && cpl_in_range && cpl_idx == IdxW'(i) && state_q[i] != SlotFree) begin
          state_q[i] <= SlotFree;
        end
        if (to_take_i && to_idx == IdxW'(i)) begin
          state_q[i] <= SlotStale;
        end
        if (alloc_i && free_idx_o == IdxW'(i)) begin
          state_q[i] <= SlotPend;
          iova_q[i]  <= alloc_iova_i;
          age_q[i]   <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/rv_iommu_atr_requester.sv
// Device-side initiator of the address-translation request/completion protocol:
// tags client requests, tracks them and returns completions or local timeouts.
module rv_iommu_atr_requester
  import rv_iommu_atr_requester_pkg::*;
#(
  parameter int unsigned NUM_TAGS       = 8,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [51:0]                   req_iova_i,
  input  logic [23:0]                   req_device_id_i,
  input  logic [19:0]                   req_process_id_i,
  input  logic [1:0]                    req_addr_type_i,
  input  logic                          req_read_write_i,
  input  logic                          req_pid_valid_i,
  input  logic                          req_no_write_i,
  input  logic                          req_exec_req_i,
  input  logic                          req_priv_req_i,
  input  logic                          req_tee_req_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  output logic [51:0]                   atr_iova_o,
  output logic [23:0]                   atr_device_id_o,
  output logic [19:0]                   atr_process_id_o,
  output logic [1:0]                    atr_addr_type_o,
  output logic                          atr_read_write_o,
  output logic                          atr_pid_valid_o,
  output logic                          atr_no_write_o,
  output logic                          atr_exec_req_o,
  output logic                          atr_priv_req_o,
  output logic                          atr_tee_req_o,
  output logic [7:0]                    atr_tag_o,
  output logic                          atr_irdy_o,
  input  logic                          atr_trdy_i,
  input  logic [2:0]                    atc_status_i,
  input  logic [33:0]                   atc_resp_pa_i,
  input  logic [7:0]                    atc_tag_i,
  input  logic                          atc_size_i,
  input  logic                          atc_no_snoop_i,
  input  logic                          atc_cxl_io_i,
  input  logic                          atc_g_i,
  input  logic                          atc_priv_i,
  input  logic                          atc_exe_i,
  input  logic                          atc_u_i,
  input  logic                          atc_r_i,
  input  logic                          atc_w_i,
  input  logic                          atc_irdy_i,
  output logic                          atc_trdy_o,
  output logic [2:0]                    rsp_status_o,
  output logic [33:0]                   rsp_pa_o,
  output logic [51:0]                   rsp_iova_o,
  output logic [8:0]                    rsp_flags_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          unexp_tag_o,
  output logic [$clog2(NUM_TAGS+1)-1:0] stale_cnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_TAGS);

  logic            any_free;
  logic [IdxW-1:0] free_idx;
  logic            cpl_pend;
  logic            cpl_stale;
  logic [51:0]     cpl_iova;
  logic            to_valid;
  logic [51:0]     to_iova;

  logic alloc;
  logic cpl_acc;
  logic cpl_load;
  logic to_take;

  atr_req_t      req_in;
  atr_req_t      atr_q;
  logic [7:0]    atr_tag_q;
  logic          atr_irdy_q;

  logic                rsp_valid_q;
  logic [2:0]          rsp_status_q;
  logic [33:0]         rsp_pa_q;
  logic [51:0]         rsp_iova_q;
  logic [NumFlags-1:0] rsp_flags_q;
  logic [NumFlags-1:0] cpl_flags;
  logic                unexp_q;

  assign req_in = '{
    iova:       req_iova_i,
    device_id:  req_device_id_i,
    process_id: req_process_id_i,
    addr_type:  req_addr_type_i,
    read_write: req_read_write_i,
    pid_valid:  req_pid_valid_i,
    no_write:   req_no_write_i,
    exec_req:   req_exec_req_i,
    priv_req:   req_priv_req_i,
    tee_req:    req_tee_req_i
  };

  always_comb begin
    cpl_flags              = '0;
    cpl_flags[FlagW]       = atc_w_i;
    cpl_flags[FlagR]       = atc_r_i;
    cpl_flags[FlagU]       = atc_u_i;
    cpl_flags[FlagExe]     = atc_exe_i;
    cpl_flags[FlagPriv]    = atc_priv_i;
    cpl_flags[FlagG]       = atc_g_i;
    cpl_flags[FlagCxlIo]   = atc_cxl_io_i;
    cpl_flags[FlagNoSnoop] = atc_no_snoop_i;
    cpl_flags[FlagSize]    = atc_size_i;
  end

  assign req_ready_o = any_free && (!atr_irdy_q || atr_trdy_i);
  assign alloc       = req_valid_i && req_ready_o;
  // Deliberately tag-independent: even dropped completions wait for a free response slot.
  assign atc_trdy_o  = !rsp_valid_q || rsp_ready_i;
  assign cpl_acc     = atc_irdy_i && atc_trdy_o;
  assign cpl_load    = cpl_acc && cpl_pend;
  assign to_take     = to_valid && atc_trdy_o && !cpl_load;

  rv_iommu_atr_tag_table #(
    .NUM_TAGS       (NUM_TAGS),
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tag_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_i      (alloc),
    .alloc_iova_i (req_iova_i),
    .any_free_o   (any_free),
    .free_idx_o   (free_idx),
    .cpl_i        (cpl_acc),
    .cpl_tag_i    (atc_tag_i),
    .cpl_pend_o   (cpl_pend),
    .cpl_stale_o  (cpl_stale),
    .cpl_iova_o   (cpl_iova),
    .to_take_i    (to_take),
    .to_valid_o   (to_valid),
    .to_iova_o    (to_iova),
    .stale_cnt_o  (stale_cnt_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atr_q      <= '0;
      atr_tag_q  <= '0;
      atr_irdy_q <= 1'b0;
    end else if (alloc) begin
      atr_q      <= req_in;
      atr_tag_q  <= 8'(free_idx);
      atr_irdy_q <= 1'b1;
    end else if (atr_trdy_i) begin
      atr_irdy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
      rsp_pa_q     <= '0;
      rsp_iova_q   <= '0;
      rsp_flags_q  <= '0;
      unexp_q      <= 1'b0;
    end else begin
      unexp_q <= cpl_acc && !cpl_pend && !cpl_stale;
      if (cpl_load) begin
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= atc_status_i;
        rsp_pa_q     <= atc_resp_pa_i;
        rsp_iova_q   <= cpl_iova;
        rsp_flags_q  <= cpl_flags;
      end else if (to_take) begin
        rsp_valid_q  <= 1'b1;
        rsp_status_q <= AtsTimeout;
        rsp_pa_q     <= '0;
        rsp_iova_q   <= to_iova;
        rsp_flags_q  <= '0;
      end else if (rsp_ready_i) begin
        rsp_valid_q  <= 1'b0;
      end
    end
  end

  assign atr_iova_o       = atr_q.iova;
  assign atr_device_id_o  = atr_q.device_id;
  assign atr_process_id_o = atr_q.process_id;
  assign atr_addr_type_o  = atr_q.addr_type;
  assign atr_read_write_o = atr_q.read_write;
  assign atr_pid_valid_o  = atr_q.pid_valid;
  assign atr_no_write_o   = atr_q.no_write;
  assign atr_exec_req_o   = atr_q.exec_req;
  assign atr_priv_req_o   = atr_q.priv_req;
  assign atr_tee_req_o    = atr_q.tee_req;
  assign atr_tag_o        = atr_tag_q;
  assign atr_irdy_o       = atr_irdy_q;

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_status_o = rsp_status_q;
  assign rsp_pa_o     = rsp_pa_q;
  assign rsp_iova_o   = rsp_iova_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign unexp_tag_o  = unexp_q;

endmodule

// File: tb/tb_rv_iommu_atr_requester.sv
// Directed bench for rv_iommu_atr_requester with an 8-tag table and a 16-cycle timeout.
module tb_rv_iommu_atr_requester;
  import rv_iommu_atr_requester_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [51:0] req_iova_i;
  logic [23:0] req_device_id_i;
  logic [19:0] req_process_id_i;
  logic [1:0]  req_addr_type_i;
  logic        req_read_write_i, req_pid_valid_i, req_no_write_i;
  logic        req_exec_req_i, req_priv_req_i, req_tee_req_i;
  logic        req_valid_i, req_ready_o;
  logic [51:0] atr_iova_o;
  logic [23:0] atr_device_id_o;
  logic [19:0] atr_process_id_o;
  logic [1:0]  atr_addr_type_o;
  logic        atr_read_write_o, atr_pid_valid_o, atr_no_write_o;
  logic        atr_exec_req_o, atr_priv_req_o, atr_tee_req_o;
  logic [7:0]  atr_tag_o;
  logic        atr_irdy_o, atr_trdy_i;
  logic [2:0]  atc_status_i;
  logic [33:0] atc_resp_pa_i;
  logic [7:0]  atc_tag_i;
  logic        atc_size_i, atc_no_snoop_i, atc_cxl_io_i, atc_g_i, atc_priv_i;
  logic        atc_exe_i, atc_u_i, atc_r_i, atc_w_i;
  logic        atc_irdy_i, atc_trdy_o;
  logic [2:0]  rsp_status_o;
  logic [33:0] rsp_pa_o;
  logic [51:0] rsp_iova_o;
  logic [8:0]  rsp_flags_o;
  logic        rsp_valid_o, rsp_ready_i;
  logic        unexp_tag_o;
  logic [3:0]  stale_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  rv_iommu_atr_requester #(
    .NUM_TAGS       (8),
    .TIMEOUT_W      (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_iova_i       (req_iova_i),
    .req_device_id_i  (req_device_id_i),
    .req_process_id_i (req_process_id_i),
    .req_addr_type_i  (req_addr_type_i),
    .req_read_write_i (req_read_write_i),
    .req_pid_valid_i  (req_pid_valid_i),
    .req_no_write_i   (req_no_write_i),
    .req_exec_req_i   (req_exec_req_i),
    .req_priv_req_i   (req_priv_req_i),
    .req_tee_req_i    (req_tee_req_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .atr_iova_o       (atr_iova_o),
    .atr_device_id_o  (atr_device_id_o),
    .atr_process_id_o (atr_process_id_o),
    .atr_addr_type_o  (atr_addr_type_o),
    .atr_read_write_o (atr_read_write_o),
    .atr_pid_valid_o  (atr_pid_valid_o),
    .atr_no_write_o   (atr_no_write_o),
    .atr_exec_req_o   (atr_exec_req_o),
    .atr_priv_req_o   (atr_priv_req_o),
    .atr_tee_req_o    (atr_tee_req_o),
    .atr_tag_o        (atr_tag_o),
    .atr_irdy_o       (atr_irdy_o),
    .atr_trdy_i       (atr_trdy_i),
    .atc_status_i     (atc_status_i),
    .atc_resp_pa_i    (atc_resp_pa_i),
    .atc_tag_i        (atc_tag_i),
    .atc_size_i       (atc_size_i),
    .atc_no_snoop_i   (atc_no_snoop_i),
    .atc_cxl_io_i     (atc_cxl_io_i),
    .atc_g_i          (atc_g_i),
    .atc_priv_i       (atc_priv_i),
    .atc_exe_i        (atc_exe_i),
    .atc_u_i          (atc_u_i),
    .atc_r_i          (atc_r_i),
    .atc_w_i          (atc_w_i),
    .atc_irdy_i       (atc_irdy_i),
    .atc_trdy_o       (atc_trdy_o),
    .rsp_status_o     (rsp_status_o),
    .rsp_pa_o         (rsp_pa_o),
    .rsp_iova_o       (rsp_iova_o),
    .rsp_flags_o      (rsp_flags_o),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .unexp_tag_o      (unexp_tag_o),
    .stale_cnt_o      (stale_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_iova_i = '0; req_device_id_i = '0; req_process_id_i = '0;
    req_addr_type_i = '0; req_read_write_i = 0; req_pid_valid_i = 0; req_no_write_i = 0;
    req_exec_req_i = 0; req_priv_req_i = 0; req_tee_req_i = 0;
    atr_trdy_i = 1'b1; rsp_ready_i = 1'b1;
    atc_irdy_i = 1'b0; atc_status_i = '0; atc_resp_pa_i = '0; atc_tag_i = '0;
    atc_size_i = 0; atc_no_snoop_i = 0; atc_cxl_io_i = 0; atc_g_i = 0; atc_priv_i = 0;
    atc_exe_i = 0; atc_u_i = 0; atc_r_i = 0; atc_w_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_req(input logic [51:0] iova);
    req_iova_i = iova; req_device_id_i = 24'hC0FFEE; req_process_id_i = 20'h12345;
    req_addr_type_i = 2'b01; req_read_write_i = 1; req_pid_valid_i = 1; req_no_write_i = 0;
    req_exec_req_i = 0; req_priv_req_i = 1; req_tee_req_i = 0;
    req_valid_i = 1'b1;
  endtask

  // Flags size, g and r set: expected rsp_flags 9'h122.
  task automatic drive_cpl(input logic [7:0] tag, input logic [2:0] st, input logic [33:0] pa);
    atc_tag_i = tag; atc_status_i = st; atc_resp_pa_i = pa;
    atc_size_i = 1; atc_g_i = 1; atc_r_i = 1;
    atc_irdy_i = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    atr_trdy_i = 1'b0;
    drive_req(52'hABCD000);
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_irdy_o !== 1'b1) $display("FAIL reset_pre_irdy: got %b want 1", atr_irdy_o);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (atr_irdy_o !== 1'b0 || atr_iova_o !== 52'h0 || atr_tag_o !== 8'h0)
      $display("FAIL reset_atr: irdy %b iova %h tag %h want 0", atr_irdy_o, atr_iova_o, atr_tag_o);
    else n_pass++;
    n_checks++;
    if (rsp_valid_o !== 1'b0 || unexp_tag_o !== 1'b0 || stale_cnt_o !== 4'd0 || rsp_iova_o !== 52'h0)
      $display("FAIL reset_rsp: valid %b unexp %b stale %0d iova %h want 0",
               rsp_valid_o, unexp_tag_o, stale_cnt_o, rsp_iova_o);
    else n_pass++;
    step();
    rst_n = 1'b1;
    atr_trdy_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1 || atc_trdy_o !== 1'b1)
      $display("FAIL reset_ready: req_ready %b atc_trdy %b want 1 1", req_ready_o, atc_trdy_o);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    drive_req(52'h12345678000);
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) $display("FAIL single_ready: got %b want 1", req_ready_o);
    else n_pass++;
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_irdy_o !== 1'b1 || atr_tag_o !== 8'd0 || atr_iova_o !== 52'h12345678000)
      $display("FAIL single_issue: irdy %b tag %0d iova %h want 1 0 12345678000",
               atr_irdy_o, atr_tag_o, atr_iova_o);
    else n_pass++;
    n_checks++;
    if (atr_device_id_o !== 24'hC0FFEE || atr_process_id_o !== 20'h12345 || atr_addr_type_o !== 2'b01 ||
        {atr_read_write_o, atr_pid_valid_o, atr_no_write_o, atr_exec_req_o, atr_priv_req_o,
         atr_tee_req_o} !== 6'b110010)
      $display("FAIL single_fields: dev %h pid %h at %b attrs %b%b%b%b%b%b want c0ffee 12345 01 110010",
               atr_device_id_o, atr_process_id_o, atr_addr_type_o, atr_read_write_o,
               atr_pid_valid_o, atr_no_write_o, atr_exec_req_o, atr_priv_req_o, atr_tee_req_o);
    else n_pass++;
    step();
    n_checks++;
    if (atr_irdy_o !== 1'b0) $display("FAIL single_handoff: irdy %b want 0", atr_irdy_o);
    else n_pass++;
    drive_cpl(8'd0, AtsSuccess, 34'h3_0000_0001);
    #1;
    n_checks++;
    if (atc_trdy_o !== 1'b1 || rsp_valid_o !== 1'b0)
      $display("FAIL single_pre_cpl: atc_trdy %b rsp_valid %b want 1 0", atc_trdy_o, rsp_valid_o);
    else n_pass++;
    step();
    atc_irdy_i = 1'b0;
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_iova_o !== 52'h12345678000 || rsp_pa_o !== 34'h3_0000_0001 ||
        rsp_status_o !== AtsSuccess || rsp_flags_o !== 9'h122)
      $display("FAIL single_rsp: v %b iova %h pa %h st %b fl %h want 1 12345678000 300000001 000 122",
               rsp_valid_o, rsp_iova_o, rsp_pa_o, rsp_status_o, rsp_flags_o);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b0) $display("FAIL single_rsp_drain: valid %b want 0", rsp_valid_o);
    else n_pass++;
    drive_req(52'hAAAAB000);
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_tag_o !== 8'd0 || atr_irdy_o !== 1'b1)
      $display("FAIL single_tag_reuse: tag %0d irdy %b want 0 1", atr_tag_o, atr_irdy_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_req(52'((i + 1) << 12));
      step();
      n_checks++;
      if (atr_tag_o !== 8'(i) || atr_irdy_o !== 1'b1)
        $display("FAIL fill_tag: tag %0d irdy %b want %0d 1", atr_tag_o, atr_irdy_o, i);
      else n_pass++;
    end
    drive_req(52'h99000);
    #1;
    n_checks++;
    if (req_ready_o !== 1'b0) $display("FAIL fill_full_ready: got %b want 0", req_ready_o);
    else n_pass++;
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_irdy_o !== 1'b0) $display("FAIL fill_no_alloc: irdy %b want 0", atr_irdy_o);
    else n_pass++;
    drive_cpl(8'd5, AtsUr, 34'h5);
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_iova_o !== 52'h6000 || rsp_status_o !== AtsUr)
      $display("FAIL fill_cpl5: v %b iova %h st %b want 1 6000 001", rsp_valid_o, rsp_iova_o, rsp_status_o);
    else n_pass++;
    drive_cpl(8'd2, AtsCrs, 34'h2);
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_iova_o !== 52'h3000 || rsp_status_o !== AtsCrs)
      $display("FAIL fill_cpl2: v %b iova %h st %b want 1 3000 010", rsp_valid_o, rsp_iova_o, rsp_status_o);
    else n_pass++;
    drive_cpl(8'd7, AtsSuccess, 34'h7);
    step();
    atc_irdy_i = 1'b0;
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_iova_o !== 52'h8000 || rsp_pa_o !== 34'h7)
      $display("FAIL fill_cpl7: v %b iova %h pa %h want 1 8000 7", rsp_valid_o, rsp_iova_o, rsp_pa_o);
    else n_pass++;
    drive_req(52'hABCD000);
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) $display("FAIL fill_ready_again: got %b want 1", req_ready_o);
    else n_pass++;
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_tag_o !== 8'd2) $display("FAIL fill_lowest_free: tag %0d want 2", atr_tag_o);
    else n_pass++;
  endtask

  task automatic test_trdy_stall();
    logic ok;
    do_reset();
    atr_trdy_i = 1'b0;
    drive_req(52'h55555000);
    step();
    drive_req(52'h66666000);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (atr_irdy_o !== 1'b1 || atr_tag_o !== 8'd0 || atr_iova_o !== 52'h55555000 ||
          req_ready_o !== 1'b0) ok = 1'b0;
      step();
    end
    n_checks++;
    if (ok !== 1'b1)
      $display("FAIL stall_hold: irdy %b tag %0d iova %h ready %b want 1 0 55555000 0",
               atr_irdy_o, atr_tag_o, atr_iova_o, req_ready_o);
    else n_pass++;
    atr_trdy_i = 1'b1;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", req_ready_o);
    else n_pass++;
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_irdy_o !== 1'b1 || atr_tag_o !== 8'd1 || atr_iova_o !== 52'h66666000)
      $display("FAIL stall_b2b: irdy %b tag %0d iova %h want 1 1 66666000",
               atr_irdy_o, atr_tag_o, atr_iova_o);
    else n_pass++;
    step();
    n_checks++;
    if (atr_irdy_o !== 1'b0) $display("FAIL stall_drain: irdy %b want 0", atr_irdy_o);
    else n_pass++;
  endtask

  task automatic test_unexpected();
    do_reset();
    drive_cpl(8'd3, AtsSuccess, 34'h0);
    #1;
    n_checks++;
    if (atc_trdy_o !== 1'b1) $display("FAIL unexp_trdy: got %b want 1", atc_trdy_o);
    else n_pass++;
    step();
    atc_irdy_i = 1'b0;
    n_checks++;
    if (unexp_tag_o !== 1'b1 || rsp_valid_o !== 1'b0)
      $display("FAIL unexp_pulse: unexp %b rsp_valid %b want 1 0", unexp_tag_o, rsp_valid_o);
    else n_pass++;
    step();
    n_checks++;
    if (unexp_tag_o !== 1'b0) $display("FAIL unexp_single: unexp %b want 0", unexp_tag_o);
    else n_pass++;
    drive_cpl(8'd200, AtsSuccess, 34'h0);
    step();
    atc_irdy_i = 1'b0;
    n_checks++;
    if (unexp_tag_o !== 1'b1 || rsp_valid_o !== 1'b0)
      $display("FAIL unexp_range: unexp %b rsp_valid %b want 1 0", unexp_tag_o, rsp_valid_o);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int edges;
    do_reset();
    drive_req(52'h10000);
    step();
    drive_req(52'h20000);
    step();
    req_valid_i = 1'b0;
    drive_cpl(8'd0, AtsSuccess, 34'h1);
    step();
    atc_irdy_i = 1'b0;
    step();
    // Tag 1 was allocated two edges ago; age hits 16 after 16 edges, response loads on the next.
    edges = 2;
    while (rsp_valid_o !== 1'b1 && edges < 30) begin
      step();
      edges++;
    end
    n_checks++;
    if (edges !== 17) $display("FAIL to_latency: got %0d edges want 17", edges);
    else n_pass++;
    n_checks++;
    if (rsp_status_o !== AtsTimeout || rsp_iova_o !== 52'h20000 || rsp_pa_o !== 34'h0 ||
        rsp_flags_o !== 9'h0)
      $display("FAIL to_rsp: st %b iova %h pa %h fl %h want 111 20000 0 0",
               rsp_status_o, rsp_iova_o, rsp_pa_o, rsp_flags_o);
    else n_pass++;
    n_checks++;
    if (stale_cnt_o !== 4'd1) $display("FAIL to_stale_cnt: got %0d want 1", stale_cnt_o);
    else n_pass++;
    drive_req(52'h30000);
    step();
    n_checks++;
    if (atr_tag_o !== 8'd0) $display("FAIL to_alloc0: tag %0d want 0", atr_tag_o);
    else n_pass++;
    drive_req(52'h40000);
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_tag_o !== 8'd2) $display("FAIL to_skip_stale: tag %0d want 2", atr_tag_o);
    else n_pass++;
    drive_cpl(8'd1, AtsSuccess, 34'h9);
    step();
    atc_irdy_i = 1'b0;
    n_checks++;
    if (rsp_valid_o !== 1'b0 || unexp_tag_o !== 1'b0 || stale_cnt_o !== 4'd0)
      $display("FAIL to_late_drop: rsp_valid %b unexp %b stale %0d want 0 0 0",
               rsp_valid_o, unexp_tag_o, stale_cnt_o);
    else n_pass++;
    drive_req(52'h50000);
    step();
    req_valid_i = 1'b0;
    n_checks++;
    if (atr_tag_o !== 8'd1) $display("FAIL to_realloc1: tag %0d want 1", atr_tag_o);
    else n_pass++;
  endtask

  task automatic test_priority();
    int w;
    do_reset();
    rsp_ready_i = 1'b0;
    drive_req(52'hA0000);
    step();
    drive_req(52'hB0000);
    step();
    drive_req(52'hC0000);
    step();
    req_valid_i = 1'b0;
    w = 0;
    while (rsp_valid_o !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== AtsTimeout || rsp_iova_o !== 52'hA0000)
      $display("FAIL prio_first_to: v %b st %b iova %h want 1 111 a0000",
               rsp_valid_o, rsp_status_o, rsp_iova_o);
    else n_pass++;
    step();
    step();
    drive_cpl(8'd2, AtsCa, 34'h2_AAAA_5555);
    #1;
    n_checks++;
    if (atc_trdy_o !== 1'b0) $display("FAIL prio_backpressure: atc_trdy %b want 0", atc_trdy_o);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_iova_o !== 52'hA0000 || rsp_valid_o !== 1'b1)
      $display("FAIL prio_hold: v %b iova %h want 1 a0000", rsp_valid_o, rsp_iova_o);
    else n_pass++;
    rsp_ready_i = 1'b1;
    step();
    atc_irdy_i = 1'b0;
    n_checks++;
    if (rsp_status_o !== AtsCa || rsp_iova_o !== 52'hC0000 || rsp_pa_o !== 34'h2_AAAA_5555)
      $display("FAIL prio_cpl_first: st %b iova %h pa %h want 100 c0000 2aaaa5555",
               rsp_status_o, rsp_iova_o, rsp_pa_o);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_status_o !== AtsTimeout || rsp_iova_o !== 52'hB0000)
      $display("FAIL prio_to_second: v %b st %b iova %h want 1 111 b0000",
               rsp_valid_o, rsp_status_o, rsp_iova_o);
    else n_pass++;
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b0 || stale_cnt_o !== 4'd2)
      $display("FAIL prio_end: v %b stale %0d want 0 2", rsp_valid_o, stale_cnt_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_trdy_stall();
    test_unexpected();
    test_timeout();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
